// File: rtl/mem_ip_bist_pkg.sv
// Shared definitions for the memory-BIST harness.
// Holds the instruction word layout, the op and address-mode encodings, the FSM state
// encoding, and a helper that assembles an instruction word from its fields.
package mem_ip_bist_pkg;

  // Instruction word width and the bit position of each field (LSB first).
  localparam int IR_WIDTH  = 22;
  localparam int ADMD_LSB  = 0;
  localparam int W_BIT     = 2;
  localparam int DATA_LSB  = 3;
  localparam int NO_LSB    = 11;
  localparam int POL_LSB   = 13;
  localparam int OP_LSB    = 17;
  localparam int UPDWN_BIT = 21;

  // OPk values.
  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  // ADMD value that restricts the element to address 0; every other value sweeps.
  localparam logic [1:0] ADMD_SINGLE = 2'd1;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Packed view of the instruction word. Members are listed MSB first, so the
  // struct bit positions line up exactly with the *_LSB / *_BIT constants above.
  typedef struct packed {
    logic       updwn;
    logic [3:0] op;
    logic [3:0] pol;
    logic [1:0] no;
    logic [7:0] data;
    logic       w;
    logic [1:0] admd;
  } ir_t;

  // Field builder: assembles an instruction word from individual fields.
  function automatic logic [IR_WIDTH-1:0] ir_build(
    input logic       updwn,
    input logic [3:0] op,
    input logic [3:0] pol,
    input logic [1:0] no,
    input logic [7:0] data,
    input logic       w,
    input logic [1:0] admd
  );
    ir_t i;
    i.updwn = updwn;
    i.op    = op;
    i.pol   = pol;
    i.no    = no;
    i.data  = data;
    i.w     = w;
    i.admd  = admd;
    return i;
  endfunction

endpackage

// File: rtl/mem_ip_ram.sv
// Single-port synchronous RAM used as the device under BIST.
// One write or one read per cycle; read data appears one cycle after the address.
// Contents are not reset.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data (old contents on a same-cycle write)
module mem_ip_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_ip_bist.sv
// Programmable memory-BIST wrapper. A small on-chip RAM plus a controller that runs
// one march element per instruction. The instruction is taken from the parallel scan
// word on a rising edge of ts. Any read miscompare clears a sticky pass/fail flag.
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous reset, active low
//   scan      in   BIST instruction word (layout in mem_ip_bist_pkg::ir_t)
//   ts        in   test start; a rising edge starts a test when idle
//   passfail  out  1 = no miscompare since the last start, 0 = miscompare seen
module mem_ip_bist
  import mem_ip_bist_pkg::*;
#(
  parameter int SCAN_WIDTH = IR_WIDTH,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FAULT_EN   = 0,
  parameter int FAULT_ADDR = 0,
  parameter int FAULT_BIT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCAN_WIDTH-1:0] scan,
  input  logic                  ts,
  output logic                  passfail
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] FAULT_A  = ADDR_WIDTH'(FAULT_ADDR);
  // Bits cleared on reads of the faulty word; all zero when injection is off.
  localparam logic [DATA_WIDTH-1:0] FAULT_MASK =
    (FAULT_EN != 0) ? ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << FAULT_BIT) : '0;

  // First address of the element for a given instruction.
  function automatic logic [ADDR_WIDTH-1:0] first_addr(input ir_t i);
    if (i.admd == ADMD_SINGLE) begin
      return '0;
    end
    return i.updwn ? ADDR_MAX : '0;
  endfunction

  logic                  ts_q;
  logic                  start;
  ir_t                   ir;
  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            op_idx;
  logic                  rd_phase;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] rdata_seen;

  logic                  cur_op;
  logic                  cur_pol;
  logic [DATA_WIDTH-1:0] data_w;
  logic [DATA_WIDTH-1:0] op_word;
  logic                  last_addr;
  logic                  miscompare;

  assign start = ts & ~ts_q;

  // Decode of the op currently being executed.
  always_comb begin
    cur_op  = ir.op[op_idx];
    cur_pol = ir.pol[op_idx];
    data_w  = DATA_WIDTH'(ir.data);
    op_word = cur_pol ? ~data_w : data_w;
  end

  // The element ends after the last address in sweep order; there is no wrap.
  always_comb begin
    if (ir.admd == ADMD_SINGLE) begin
      last_addr = 1'b1;
    end else if (ir.updwn) begin
      last_addr = (addr == '0);
    end else begin
      last_addr = (addr == ADDR_MAX);
    end
  end

  // RAM port: FILL writes DATA in ascending order, RUN writes the op's polarity of DATA.
  // During a read both cycles present the same address, so the compare cycle sees the
  // data for the address that was issued.
  always_comb begin
    ram_we    = ((state == ST_FILL) && ir.w) ||
                ((state == ST_RUN) && (cur_op == OP_WRITE));
    ram_addr  = addr;
    ram_wdata = (state == ST_FILL) ? data_w : op_word;
  end

  // Stuck-at-0 injection on the read path of one word.
  always_comb begin
    rdata_seen = ram_rdata;
    if (addr == FAULT_A) begin
      rdata_seen = ram_rdata & ~FAULT_MASK;
    end
  end

  assign miscompare = (rdata_seen != op_word);

  mem_ip_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q     <= 1'b0;
      ir       <= '0;
      state    <= ST_IDLE;
      addr     <= '0;
      op_idx   <= '0;
      rd_phase <= 1'b0;
      passfail <= 1'b1;
    end else begin
      ts_q <= ts;
      case (state)
        ST_IDLE: begin
          // Start edges arriving while busy are dropped; only IDLE looks at them.
          if (start) begin
            ir       <= ir_t'(scan);
            passfail <= 1'b1;
            op_idx   <= '0;
            rd_phase <= 1'b0;
            if (scan[W_BIT]) begin
              state <= ST_FILL;
              addr  <= '0;
            end else begin
              state <= ST_RUN;
              addr  <= first_addr(ir_t'(scan));
            end
          end
        end

        ST_FILL: begin
          if (addr == ADDR_MAX) begin
            state <= ST_RUN;
            addr  <= first_addr(ir);
          end else begin
            addr <= addr + 1'b1;
          end
        end

        ST_RUN: begin
          if ((cur_op == OP_READ) && !rd_phase) begin
            // Read issue cycle; the compare happens next cycle.
            rd_phase <= 1'b1;
          end else begin
            rd_phase <= 1'b0;
            if (rd_phase && miscompare) begin
              passfail <= 1'b0;
            end
            if (op_idx == ir.no) begin
              op_idx <= '0;
              if (last_addr) begin
                state <= ST_DONE;
              end else if (ir.updwn) begin
                addr <= addr - 1'b1;
              end else begin
                addr <= addr + 1'b1;
              end
            end else begin
              op_idx <= op_idx + 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ip_bist.sv
module tb_mem_ip_bist;
  import mem_ip_bist_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [21:0] scan = '0;
  logic        ts = 1'b0;
  logic        ts_f = 1'b0;
  logic        passfail;
  logic        passfail_f;

  always #5 clk = ~clk;

  mem_ip_bist #(
    .SCAN_WIDTH (22), .ADDR_WIDTH (4), .DATA_WIDTH (8),
    .FAULT_EN (0), .FAULT_ADDR (0), .FAULT_BIT (0)
  ) dut (
    .clk (clk), .rst (rst), .scan (scan), .ts (ts), .passfail (passfail)
  );

  mem_ip_bist #(
    .SCAN_WIDTH (22), .ADDR_WIDTH (4), .DATA_WIDTH (8),
    .FAULT_EN (1), .FAULT_ADDR (5), .FAULT_BIT (1)
  ) dut_f (
    .clk (clk), .rst (rst), .scan (scan), .ts (ts_f), .passfail (passfail_f)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [21:0] ir;
    logic        pf;
    string       name;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [21:0] mk_ir(input logic updwn, input logic [3:0] op,
                                        input logic [3:0] pol, input logic [1:0] no,
                                        input logic [7:0] data, input logic w,
                                        input logic [1:0] admd);
    return {updwn, op, pol, no, data, w, admd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: queues the RAM writes an instruction must produce and
  // returns its length in cycles from the start edge to the return to IDLE.
  task automatic model_cmd(input logic [21:0] ir, output int cyc);
    logic [1:0] admd;
    logic       w;
    logic [7:0] data;
    logic [1:0] no;
    logic [3:0] pol;
    logic [3:0] op;
    logic       updwn;
    int         n;
    logic [3:0] a;
    wr_t        e;
    admd  = ir[1:0];
    w     = ir[2];
    data  = ir[10:3];
    no    = ir[12:11];
    pol   = ir[16:13];
    op    = ir[20:17];
    updwn = ir[21];
    cyc = 0;
    if (w) begin
      for (int i = 0; i < 16; i++) begin
        e.addr = 4'(i);
        e.data = data;
        exp_q.push_back(e);
        cyc++;
      end
    end
    n = (admd == 2'd1) ? 1 : 16;
    for (int i = 0; i < n; i++) begin
      if (admd == 2'd1) a = 4'd0;
      else a = updwn ? 4'(15 - i) : 4'(i);
      for (int k = 0; k <= int'(no); k++) begin
        if (op[k] == 1'b0) begin
          e.addr = a;
          e.data = pol[k] ? ~data : data;
          exp_q.push_back(e);
          cyc += 1;
        end else begin
          cyc += 2;
        end
      end
    end
    cyc += 1;
  endtask

  // Write-port scoreboard for the fault-free instance.
  always @(negedge clk) begin
    if (dut.ram_we === 1'b1) begin
      wr_t e;
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0h data %0h, expected no write (t=%0t)",
                 dut.ram_addr, dut.ram_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        if (dut.ram_addr !== e.addr || dut.ram_wdata !== e.data) begin
          errors++;
          $display("FAIL wr_seq: got addr %0h data %0h, expected addr %0h data %0h (t=%0t)",
                   dut.ram_addr, dut.ram_wdata, e.addr, e.data, $time);
        end
      end
    end
  end

  task automatic run_cmd(input logic [21:0] ir, input logic pf, input string name);
    int cyc;
    @(negedge clk);
    scan = ir;
    ts   = 1'b1;
    model_cmd(ir, cyc);
    @(negedge clk);
    ts = 1'b0;
    repeat (cyc - 1) @(negedge clk);
    chk({name, "_done_state"}, 32'(dut.state), 32'(ST_DONE));
    @(negedge clk);
    chk({name, "_idle_state"}, 32'(dut.state), 32'(ST_IDLE));
    chk({name, "_passfail"}, 32'(passfail), 32'(pf));
    chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] base_ir, fault_ir, a_ir, b_ir, fail_ir;
    int cyc, wr_before;

    base_ir  = mk_ir(1'b0, 4'b0100, 4'b0000, 2'd3, 8'hFA, 1'b0, 2'd1);
    fault_ir = mk_ir(1'b0, 4'b0001, 4'b0000, 2'd0, 8'hFF, 1'b1, 2'd0);
    a_ir     = mk_ir(1'b0, 4'b0001, 4'b0000, 2'd1, 8'hAA, 1'b0, 2'd0);
    b_ir     = mk_ir(1'b0, 4'b0000, 4'b1111, 2'd3, 8'h00, 1'b1, 2'd0);
    fail_ir  = mk_ir(1'b0, 4'b0001, 4'b0000, 2'd0, 8'h55, 1'b0, 2'd0);

    tbl[0] = '{base_ir, 1'b1, "base"};
    tbl[1] = '{mk_ir(1'b0, 4'b0001, 4'b0010, 2'd1, 8'h55, 1'b1, 2'd0), 1'b1, "march_up"};
    tbl[2] = '{mk_ir(1'b1, 4'b0001, 4'b0001, 2'd0, 8'h55, 1'b0, 2'd0), 1'b1, "march_down"};
    tbl[3] = '{mk_ir(1'b0, 4'b0001, 4'b0000, 2'd0, 8'hAA, 1'b0, 2'd0), 1'b1, "verify_aa"};
    tbl[4] = '{mk_ir(1'b1, 4'b0001, 4'b0000, 2'd0, 8'hAA, 1'b0, 2'd2), 1'b1, "verify_admd2"};
    tbl[5] = '{fail_ir, 1'b0, "mismatch"};
    tbl[6] = '{mk_ir(1'b1, 4'b0001, 4'b0001, 2'd0, 8'h55, 1'b0, 2'd0), 1'b1, "restore"};
    tbl[7] = '{mk_ir(1'b0, 4'b0001, 4'b0000, 2'd0, 8'hAA, 1'b0, 2'd1), 1'b1, "single_read"};

    // Reset for 10 ns, then release on a falling clock edge.
    @(negedge clk);
    rst = 1'b1;
    chk("reset_passfail", 32'(passfail), 32'd1);
    chk("reset_passfail_f", 32'(passfail_f), 32'd1);
    chk("reset_state", 32'(dut.state), 32'(ST_IDLE));
    repeat (5) @(negedge clk);
    chk("idle_no_writes", 32'(wr_cnt), 32'd0);

    // Table of instructions against the fault-free instance.
    foreach (tbl[i]) run_cmd(tbl[i].ir, tbl[i].pf, tbl[i].name);
    for (int i = 0; i < 16; i++) chk($sformatf("mem_aa_%0d", i), 32'(dut.u_ram.mem[i]), 32'hAA);

    // Stuck-at-0 on bit 1 of word 5: flag falls exactly at that word's compare.
    @(negedge clk);
    scan = fault_ir;
    ts_f = 1'b1;
    @(negedge clk);
    ts_f = 1'b0;
    repeat (27) @(negedge clk);
    chk("fault_before_addr5", 32'(passfail_f), 32'd1);
    @(negedge clk);
    chk("fault_at_addr5", 32'(passfail_f), 32'd0);
    repeat (21) @(negedge clk);
    chk("fault_end_state", 32'(dut_f.state), 32'(ST_IDLE));
    chk("fault_sticky", 32'(passfail_f), 32'd0);
    scan = base_ir;
    ts_f = 1'b1;
    @(negedge clk);
    ts_f = 1'b0;
    repeat (6) @(negedge clk);
    chk("fault_clean_state", 32'(dut_f.state), 32'(ST_IDLE));
    chk("fault_clean_passfail", 32'(passfail_f), 32'd1);
    chk("fault_main_untouched", 32'(dut.state), 32'(ST_IDLE));

    // ts held high for 3 cycles, then re-pulsed mid-test with a different word.
    @(negedge clk);
    scan = a_ir;
    ts   = 1'b1;
    model_cmd(a_ir, cyc);
    for (int c = 1; c <= cyc + 1; c++) begin
      @(negedge clk);
      if (c == 3) ts = 1'b0;
      if (c == 6) begin
        scan = b_ir;
        ts   = 1'b1;
      end
      if (c == 7) ts = 1'b0;
      if (c == cyc) chk("hold_done_state", 32'(dut.state), 32'(ST_DONE));
    end
    chk("hold_idle_state", 32'(dut.state), 32'(ST_IDLE));
    chk("hold_passfail", 32'(passfail), 32'd1);
    chk("hold_ir_kept", 32'(dut.ir), 32'(a_ir));
    chk("hold_writes_left", 32'(exp_q.size()), 32'd0);
    wr_before = wr_cnt;
    repeat (5) @(negedge clk);
    chk("hold_no_restart", 32'(wr_cnt), 32'(wr_before));

    // Asynchronous reset in the middle of a failing sweep.
    @(negedge clk);
    scan = fail_ir;
    ts   = 1'b1;
    @(negedge clk);
    ts = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrst_failing", 32'(passfail), 32'd0);
    chk("midrst_busy", 32'(dut.state), 32'(ST_RUN));
    #2 rst = 1'b0;
    #1;
    chk("midrst_passfail", 32'(passfail), 32'd1);
    chk("midrst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("midrst_ir", 32'(dut.ir), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    run_cmd(base_ir, 1'b1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
